// File: rtl/mem_stream_reader.sv
// Read-side sequencer: issues LEN consecutive reads from BASE to a single-port memory with a
// 1-cycle registered read, and replays the returned words as an in-order valid/ready stream.
module mem_stream_reader #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_nwr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     remain_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic [DATA_W-1:0]   buf_data_q [2];
  logic                buf_last_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  logic                pop;
  logic                push;
  logic [2:0]          occ;
  logic                issue;
  logic                final_issue;

  // Handshake: a word transfers at a posedge where out_valid && out_ready; while stalled
  // (valid && !ready) the presented word and its last flag are held unchanged.
  always_comb begin
    pop         = (count_q != 2'd0) && out_ready;
    push        = inflight_q;
    // Words already buffered plus the one on the memory bus must leave room for a new read.
    occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = (state_q == ST_RUN) && (occ < 3'd2);
    final_issue = issue && (remain_q == LEN_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= len;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_ONE;
            remain_q <= remain_q - LEN_ONE;
            if (final_issue) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && buf_last_q[rd_ptr_q]) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Two-entry FIFO catching the word that returns one cycle after each issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_nwr  = 1'b1;
  assign mem_addr    = addr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = buf_data_q[rd_ptr_q];
  assign out_last    = (count_q != 2'd0) && buf_last_q[rd_ptr_q];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: behavioural memory, directed and random transfers, and a
// scoreboard fed from a per-transfer word list built directly from base/len/memory contents.
module tb_mem_stream_reader;

  localparam int SIZE   = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy;
  logic              done;
  logic              mem_rd_nwr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        dbg_state;

  mem_stream_reader #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_rd_nwr(mem_rd_nwr), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .dbg_state_o(dbg_state)
  );

  // ---- clock / reset / memory ----
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem_arr [SIZE];
  always @(posedge clk) mem_data <= mem_arr[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- checking ----
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- scoreboard / reference model ----
  logic [DATA_W:0] exp_q[$];
  logic            busy_m = 1'b0;
  logic            done_pend = 1'b0;
  int              first_valid_cyc = -1;
  int              last_hs_cyc = 0;
  int              hs_cnt = 0;
  logic            full_rate = 1'b0;
  logic            ready_rand = 1'b0;
  logic            prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic            prev_last = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic            hs;
    logic            busy_now;
    logic            done_now;
    logic            done_next;
    logic [DATA_W:0] e;
    int              n;
    if (!rst_n) begin
      exp_q.delete();
      busy_m          = 1'b0;
      done_pend       = 1'b0;
      first_valid_cyc = -1;
      prev_stall      = 1'b0;
    end else begin
      hs        = out_valid && out_ready;
      busy_now  = busy_m;
      done_now  = done_pend;
      done_next = 1'b0;
      check("rd_nwr", mem_rd_nwr, 1);
      check("done", done, done_now);
      check("busy", busy, busy_now);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (first_valid_cyc >= 0) begin
        if (cyc == first_valid_cyc - 1) check("pre_valid", out_valid, 0);
        if (cyc == first_valid_cyc) begin
          check("first_valid", out_valid, 1);
          first_valid_cyc = -1;
        end
      end
      if (hs) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", out_data, e[DATA_W-1:0]);
          check("last", out_last, e[DATA_W]);
          if (full_rate && hs_cnt > 0) check("rate_gap", cyc - last_hs_cyc, 1);
          last_hs_cyc = cyc;
          hs_cnt++;
          if (e[DATA_W]) begin
            busy_m    = 1'b0;
            done_next = 1'b1;
          end
        end
      end
      if (start && !busy_now && !done_now) begin
        n      = int'(len);
        hs_cnt = 0;
        for (int i = 0; i < n; i++)
          exp_q.push_back({(i == n - 1), mem_arr[(int'(base_addr) + i) % SIZE]});
        if (n == 0) done_next = 1'b1;
        else begin
          busy_m          = 1'b1;
          first_valid_cyc = cyc + 3;
        end
      end
      done_pend  = done_next;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---- driver tasks ----
  task automatic start_xfer(input int b, input int l);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    len       = (ADDR_W + 1)'(l);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_nwr"}, mem_rd_nwr, 1);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  // ---- main sequence ----
  initial begin
    for (int i = 0; i < SIZE; i++) mem_arr[i] = 32'h100 + i;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Basic transfer at full rate, then a wrapping transfer.
    full_rate = 1'b1;
    start_xfer(4, 5);
    wait_done();
    start_xfer(30, 4);
    wait_done();

    // Zero-length transfer.
    start_xfer(0, 0);
    wait_done();

    // Backpressure with a start pulse that must be ignored while busy.
    full_rate  = 1'b0;
    ready_rand = 1'b1;
    start_xfer(0, 8);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 5'd9; len = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Full-size transfer followed immediately by another.
    ready_rand = 1'b0;
    full_rate  = 1'b1;
    start_xfer(7, 32);
    wait_done();
    start_xfer(0, 32);
    wait_done();

    // Asynchronous reset in the middle of a running transfer.
    start_xfer(10, 8);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_xfer(3, 6);
    wait_done();

    // Randomized transfers over random memory contents.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < SIZE; i++) mem_arr[i] = $urandom();
      ready_rand = 1'($urandom_range(0, 1));
      full_rate  = !ready_rand;
      start_xfer($urandom_range(0, SIZE - 1), $urandom_range(0, SIZE));
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
